// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO/arbiter widths, defaults and state type
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick starting after last_owner
module rr_priority_picker #(
    parameter int NUM_REQ = fifo_pkg::NUM_REQ,
    parameter int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [OW-1:0]      pick_idx,
    output logic               any_req
);
    logic w_found;
    int   w_idx;

    // Walk last_owner+1 .. last_owner+NUM_REQ; the owner itself is checked last.
    always_comb begin
        pick     = '0;
        pick_idx = last_owner;
        any_req  = |req;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(last_owner) + k) % NUM_REQ;
            if (!w_found && req[w_idx[OW-1:0]]) begin
                w_found              = 1'b1;
                pick[w_idx[OW-1:0]]  = 1'b1;
                pick_idx             = w_idx[OW-1:0];
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_pkg::NUM_REQ,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = fifo_pkg::MAX_BURST,
    parameter int BLEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk_wr,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*BLEN_W-1:0]     req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            data_ack,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic [BLEN_W-1:0]             words_left
);
    import fifo_pkg::*;

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [BLEN_W-1:0]    r_cnt;
    logic [OW-1:0]        r_last_owner;

    logic [NUM_REQ-1:0]   w_pick;
    logic [OW-1:0]        w_pick_idx;
    logic                 w_any_req;
    logic                 w_busy;
    logic                 w_wr_en;
    logic [BLEN_W-1:0]    w_len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_len_arr[g]  = req_len[g*BLEN_W +: BLEN_W];
        assign w_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [BLEN_W-1:0] clamp_len(input logic [BLEN_W-1:0] len);
        if (len == '0)
            return BLEN_W'(1);
        else if (len > BLEN_W'(MAX_BURST))
            return BLEN_W'(MAX_BURST);
        else
            return len;
    endfunction

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_picker (
        .req        (req),
        .last_owner (r_last_owner),
        .pick       (w_pick),
        .pick_idx   (w_pick_idx),
        .any_req    (w_any_req)
    );

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_last_owner <= OW'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= BURST;
                        r_grant      <= w_pick;
                        r_cnt        <= clamp_len(w_len_arr[w_pick_idx]);
                        r_last_owner <= w_pick_idx;
                    end
                end
                BURST: begin
                    if (w_wr_en) begin
                        if (r_cnt == BLEN_W'(1)) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - BLEN_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The burst owner is always r_last_owner while busy; the write side follows full word by word.
    assign w_busy     = (r_state == BURST);
    assign w_wr_en    = w_busy && !full;
    assign busy       = w_busy;
    assign wr_en      = w_wr_en;
    assign grant      = r_grant;
    assign data_ack   = w_wr_en ? r_grant : '0;
    assign data_in    = w_busy ? w_data_arr[r_last_owner] : '0;
    assign words_left = w_busy ? r_cnt : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BW = 5;

    logic            clk_wr = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*BW-1:0] req_len;
    logic [NR*DW-1:0] req_data;
    logic            full;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   data_ack;
    logic            wr_en;
    logic [DW-1:0]   data_in;
    logic            busy;
    logic [BW-1:0]   words_left;

    int n_assert = 0;
    int n_fail   = 0;
    int overlap  = 0;
    int wcount   = 0;
    int base;
    logic [DW-1:0] head [NR];
    logic [DW-1:0] wr_log [$];

    fifo_wr_arbiter dut (
        .clk_wr     (clk_wr),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .full       (full),
        .grant      (grant),
        .data_ack   (data_ack),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .busy       (busy),
        .words_left (words_left)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        req_data = {head[3], head[2], head[1], head[0]};
    endtask

    task automatic set_len(input int i, input logic [BW-1:0] v);
        req_len[i*BW +: BW] = v;
    endtask

    // Producer/FIFO model: log writes before the edge, advance acked heads after it.
    task automatic tick();
        logic [NR-1:0] ack;
        ack = data_ack;
        if (wr_en) begin
            wr_log.push_back(data_in);
            wcount++;
        end
        if (wr_en && full) overlap++;
        @(posedge clk_wr);
        #1;
        for (int i = 0; i < NR; i++)
            if (ack[i]) head[i] = head[i] + 8'd1;
        drive_data();
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        full    = 1'b0;
        for (int i = 0; i < NR; i++) head[i] = 8'h00;
        drive_data();
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_words_left", 32'(words_left), 32'h0);
        check("rst_data_ack", 32'(data_ack), 32'h0);
        check("rst_data_in", 32'(data_in), 32'h0);
        @(posedge clk_wr);
        #1;
        rst = 1'b0;
        #1;

        // Single burst of 3 from requester 0
        head[0] = 8'hA1;
        drive_data();
        req = 4'b0001;
        set_len(0, 5'd3);
        #1;
        base = wcount;
        tick();
        req = 4'b0000;
        #1;
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_wl0", 32'(words_left), 32'd3);
        check("t1_wr0", 32'(wr_en), 32'h1);
        check("t1_d0", 32'(data_in), 32'hA1);
        check("t1_ack0", 32'(data_ack), 32'h1);
        tick();
        check("t1_wl1", 32'(words_left), 32'd2);
        check("t1_d1", 32'(data_in), 32'hA2);
        tick();
        check("t1_wl2", 32'(words_left), 32'd1);
        check("t1_d2", 32'(data_in), 32'hA3);
        tick();
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_grant_end", 32'(grant), 32'h0);
        check("t1_wr_end", 32'(wr_en), 32'h0);
        check("t1_din_idle", 32'(data_in), 32'h0);
        check("t1_writes", 32'(wcount - base), 32'd3);
        check("t1_log2", 32'(wr_log[base+2]), 32'hA3);

        // Round-robin over all four with length 1
        pulse_reset();
        for (int i = 0; i < NR; i++) set_len(i, 5'd1);
        req = 4'b1111;
        #1;
        base = wcount;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            check($sformatf("t2_wr%0d", k), 32'(wr_en), 32'h1);
            tick();
            check($sformatf("t2_idle%0d", k), 32'(busy), 32'h0);
            if (k == 4) req = 4'b0000;
            #1;
        end
        check("t2_writes", 32'(wcount - base), 32'd5);

        // Requester 2, burst of 4 with a two-cycle full stall after word 2
        head[2] = 8'h20;
        drive_data();
        set_len(2, 5'd4);
        req = 4'b0100;
        #1;
        base = wcount;
        tick();
        req = 4'b0000;
        #1;
        check("t3_grant", 32'(grant), 32'h4);
        check("t3_wl0", 32'(words_left), 32'd4);
        tick();
        tick();
        full = 1'b1;
        #1;
        check("t3_stall_wr", 32'(wr_en), 32'h0);
        check("t3_stall_ack", 32'(data_ack), 32'h0);
        check("t3_stall_wl", 32'(words_left), 32'd2);
        tick();
        check("t3_stall2_wl", 32'(words_left), 32'd2);
        check("t3_stall2_grant", 32'(grant), 32'h4);
        check("t3_stall2_din", 32'(data_in), 32'h22);
        tick();
        full = 1'b0;
        #1;
        check("t3_resume_wr", 32'(wr_en), 32'h1);
        check("t3_resume_ack", 32'(data_ack), 32'h4);
        tick();
        check("t3_wl_last", 32'(words_left), 32'd1);
        tick();
        check("t3_busy_end", 32'(busy), 32'h0);
        check("t3_writes", 32'(wcount - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_log%0d", i), 32'(wr_log[base+i]), 32'(8'h20 + 8'(i)));

        // Length clamping: 0 -> 1, 31 -> 16
        set_len(1, 5'd0);
        req = 4'b0010;
        #1;
        base = wcount;
        tick();
        req = 4'b0000;
        #1;
        check("t4_zero_grant", 32'(grant), 32'h2);
        check("t4_zero_wl", 32'(words_left), 32'd1);
        tick();
        check("t4_zero_busy", 32'(busy), 32'h0);
        check("t4_zero_writes", 32'(wcount - base), 32'd1);
        set_len(3, 5'd31);
        req = 4'b1000;
        #1;
        base = wcount;
        tick();
        req = 4'b0000;
        #1;
        check("t4_big_grant", 32'(grant), 32'h8);
        check("t4_big_wl", 32'(words_left), 32'd16);
        for (int i = 0; i < 16; i++) tick();
        check("t4_big_busy", 32'(busy), 32'h0);
        check("t4_big_writes", 32'(wcount - base), 32'd16);

        // Asynchronous reset in the middle of a burst
        set_len(0, 5'd8);
        req = 4'b0001;
        #1;
        tick();
        req = 4'b0000;
        #1;
        tick();
        tick();
        tick();
        check("t5_wl_pre", 32'(words_left), 32'd5);
        rst = 1'b1;
        #1;
        check("t5_async_grant", 32'(grant), 32'h0);
        check("t5_async_wr", 32'(wr_en), 32'h0);
        check("t5_async_busy", 32'(busy), 32'h0);
        check("t5_async_wl", 32'(words_left), 32'h0);
        rst = 1'b0;
        set_len(0, 5'd1);
        set_len(3, 5'd1);
        req = 4'b1001;
        #1;
        tick();
        req = 4'b0000;
        #1;
        check("t5_post_grant", 32'(grant), 32'h1);
        tick();
        check("t5_post_busy", 32'(busy), 32'h0);

        // Two continuous requesters alternate, with one full stall mixed in
        pulse_reset();
        set_len(0, 5'd2);
        set_len(2, 5'd2);
        req = 4'b0101;
        #1;
        base = wcount;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_grant%0d", k), 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h4);
            if (k == 1) begin
                full = 1'b1;
                #1;
                check("t6_full_wr", 32'(wr_en), 32'h0);
                tick();
                full = 1'b0;
                #1;
            end
            tick();
            tick();
            check($sformatf("t6_idle%0d", k), 32'(busy), 32'h0);
        end
        req = 4'b0000;
        #1;
        check("t6_writes", 32'(wcount - base), 32'd8);
        check("no_wr_while_full", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
